// File: rtl/cpu_pkg.sv
// Shared CPU constants: value-stack opcodes, trap codes, wasm value-type tags
// and the value-stack control FSM state type.
package cpu_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_PUSH   = 3'd1;
    localparam logic [2:0] OP_DROP   = 3'd2;
    localparam logic [2:0] OP_SELECT = 3'd3;
    localparam logic [2:0] OP_DUP    = 3'd4;

    localparam logic [3:0] TRAP_NONE      = 4'd0;
    localparam logic [3:0] TRAP_UNDERFLOW = 4'd1;
    localparam logic [3:0] TRAP_OVERFLOW  = 4'd2;
    localparam logic [3:0] TRAP_TYPE      = 4'd3;

    localparam logic [1:0] TY_I32 = 2'd0;
    localparam logic [1:0] TY_I64 = 2'd1;
    localparam logic [1:0] TY_F32 = 2'd2;
    localparam logic [1:0] TY_F64 = 2'd3;

    typedef enum logic {
        ST_RUN,
        ST_TRAPPED
    } vs_state_t;

endpackage

// File: rtl/stack_mem.sv
// Value-stack entry storage: one synchronous write port, three combinational
// read ports. Type tags are stored alongside when VALUE_STACK_TYPE_CHECK_EN is defined.
module stack_mem #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
`ifdef VALUE_STACK_TYPE_CHECK_EN
    input  logic [1:0]            wtag,
    output logic [1:0]            rtag0,
    output logic [1:0]            rtag1,
    output logic [1:0]            rtag2,
`endif
    input  logic [DEPTH_LOG2-1:0] raddr0,
    input  logic [DEPTH_LOG2-1:0] raddr1,
    input  logic [DEPTH_LOG2-1:0] raddr2,
    output logic [WIDTH-1:0]      rdata0,
    output logic [WIDTH-1:0]      rdata1,
    output logic [WIDTH-1:0]      rdata2
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

`ifdef VALUE_STACK_TYPE_CHECK_EN
    logic [1:0] tags [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            tags[waddr] <= wtag;
        end
    end

    assign rtag0 = tags[raddr0];
    assign rtag1 = tags[raddr1];
    assign rtag2 = tags[raddr2];
`endif

endmodule

// File: rtl/value_stack.sv
// Wasm-style operand stack with PUSH/DROP/SELECT/DUP and sticky traps.
// Optional per-entry type checking on SELECT when VALUE_STACK_TYPE_CHECK_EN is defined.
module value_stack
    import cpu_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            op,
    input  logic                  op_valid,
    input  logic [WIDTH-1:0]      op_data,
`ifdef VALUE_STACK_TYPE_CHECK_EN
    input  logic [1:0]            op_type,
`endif
    output logic                  op_ready,
    output logic [WIDTH-1:0]      result,
    output logic                  result_empty,
    output logic [DEPTH_LOG2:0]   depth,
    output logic [3:0]            trap
);

    localparam int                  AW    = DEPTH_LOG2;
    localparam int                  CW    = (WIDTH < 32) ? WIDTH : 32;
    localparam logic [DEPTH_LOG2:0] ZERO  = '0;
    localparam logic [DEPTH_LOG2:0] ONE   = 1;
    localparam logic [DEPTH_LOG2:0] TWO   = 2;
    localparam logic [DEPTH_LOG2:0] THREE = 3;
    localparam logic [DEPTH_LOG2:0] FULL  = ONE << DEPTH_LOG2;

    vs_state_t           state_q, state_d;
    logic [DEPTH_LOG2:0] depth_q, depth_d;
    logic [3:0]          trap_q, trap_d;

    logic                we;
    logic [AW-1:0]       waddr;
    logic [WIDTH-1:0]    wdata;
    logic [WIDTH-1:0]    rd_top, rd_m1, rd_m2;
    logic [DEPTH_LOG2:0] idx_m1, idx_m2, idx_m3;
    logic                cond_true;

    assign idx_m1 = depth_q - ONE;
    assign idx_m2 = depth_q - TWO;
    assign idx_m3 = depth_q - THREE;

`ifdef VALUE_STACK_TYPE_CHECK_EN
    logic [1:0] wtag, tag_top, tag_m1, tag_m2;
`endif

    // Storage writes are blocked while reset is asserted so reset wins over any op.
    stack_mem #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk    (clk),
        .we     (we & reset),
        .waddr  (waddr),
        .wdata  (wdata),
`ifdef VALUE_STACK_TYPE_CHECK_EN
        .wtag   (wtag),
        .rtag0  (tag_top),
        .rtag1  (tag_m1),
        .rtag2  (tag_m2),
`endif
        .raddr0 (idx_m1[AW-1:0]),
        .raddr1 (idx_m2[AW-1:0]),
        .raddr2 (idx_m3[AW-1:0]),
        .rdata0 (rd_top),
        .rdata1 (rd_m1),
        .rdata2 (rd_m2)
    );

    // Wasm select tests the condition as an i32.
    assign cond_true = |rd_top[CW-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            depth_q <= ZERO;
            trap_q  <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        trap_d  = trap_q;
        we      = 1'b0;
        waddr   = depth_q[AW-1:0];
        wdata   = op_data;
`ifdef VALUE_STACK_TYPE_CHECK_EN
        wtag    = op_type;
`endif
        if (state_q == ST_RUN && op_valid) begin
            case (op)
                OP_PUSH: begin
                    if (depth_q == FULL) begin
                        trap_d  = TRAP_OVERFLOW;
                        state_d = ST_TRAPPED;
                    end else begin
                        we      = 1'b1;
                        depth_d = depth_q + ONE;
                    end
                end
                OP_DROP: begin
                    if (depth_q == ZERO) begin
                        trap_d  = TRAP_UNDERFLOW;
                        state_d = ST_TRAPPED;
                    end else begin
                        depth_d = idx_m1;
                    end
                end
                OP_DUP: begin
                    if (depth_q == ZERO) begin
                        trap_d  = TRAP_UNDERFLOW;
                        state_d = ST_TRAPPED;
                    end else if (depth_q == FULL) begin
                        trap_d  = TRAP_OVERFLOW;
                        state_d = ST_TRAPPED;
                    end else begin
                        we      = 1'b1;
                        wdata   = rd_top;
`ifdef VALUE_STACK_TYPE_CHECK_EN
                        wtag    = tag_top;
`endif
                        depth_d = depth_q + ONE;
                    end
                end
                OP_SELECT: begin
                    if (depth_q < THREE) begin
                        trap_d  = TRAP_UNDERFLOW;
                        state_d = ST_TRAPPED;
`ifdef VALUE_STACK_TYPE_CHECK_EN
                    end else if (tag_top != TY_I32 || tag_m1 != tag_m2) begin
                        trap_d  = TRAP_TYPE;
                        state_d = ST_TRAPPED;
`endif
                    end else begin
                        // val1 (deepest) is overwritten in place by the chosen value.
                        we      = 1'b1;
                        waddr   = idx_m3[AW-1:0];
                        wdata   = cond_true ? rd_m2 : rd_m1;
`ifdef VALUE_STACK_TYPE_CHECK_EN
                        wtag    = tag_m2;
`endif
                        depth_d = idx_m2;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign op_ready     = (state_q == ST_RUN);
    assign result_empty = (depth_q == ZERO);
    assign result       = result_empty ? '0 : rd_top;
    assign depth        = depth_q;
    assign trap         = trap_q;

endmodule

// File: tb/tb_value_stack.sv
// Directed self-checking bench for value_stack (default DEPTH_LOG2=4, WIDTH=64).
// Type-check vectors are included when VALUE_STACK_TYPE_CHECK_EN is defined.
module tb_value_stack;
    import cpu_pkg::*;

    localparam int WIDTH      = 64;
    localparam int DEPTH_LOG2 = 4;

    logic                clk;
    logic                reset;
    logic [2:0]          op;
    logic                op_valid;
    logic [WIDTH-1:0]    op_data;
    logic                op_ready;
    logic [WIDTH-1:0]    result;
    logic                result_empty;
    logic [DEPTH_LOG2:0] depth;
    logic [3:0]          trap;
`ifdef VALUE_STACK_TYPE_CHECK_EN
    logic [1:0]          op_type;
`endif

    int checks = 0;
    int errors = 0;

    value_stack #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .op_valid     (op_valid),
        .op_data      (op_data),
`ifdef VALUE_STACK_TYPE_CHECK_EN
        .op_type      (op_type),
`endif
        .op_ready     (op_ready),
        .result       (result),
        .result_empty (result_empty),
        .depth        (depth),
        .trap         (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic do_op(input logic [2:0] o, input logic [63:0] d);
        @(negedge clk);
        op       = o;
        op_data  = d;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

`ifdef VALUE_STACK_TYPE_CHECK_EN
    task automatic do_push_t(input logic [1:0] t, input logic [63:0] d);
        op_type = t;
        do_op(OP_PUSH, d);
        op_type = TY_I32;
    endtask
`endif

    task automatic do_reset();
        @(negedge clk);
        op_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        op       = OP_NOP;
        op_valid = 1'b0;
        op_data  = '0;
`ifdef VALUE_STACK_TYPE_CHECK_EN
        op_type  = TY_I32;
`endif

        // Reset state
        do_reset();
        check("rst_depth", 64'(depth), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_empty", 64'(result_empty), 64'd1);
        check("rst_trap", 64'(trap), 64'd0);
        check("rst_ready", 64'(op_ready), 64'd1);

        // PUSH latency, DUP, DROP
        do_op(OP_PUSH, 64'h1234_5678_9abc_def0);
        check("push_result", result, 64'h1234_5678_9abc_def0);
        check("push_depth", 64'(depth), 64'd1);
        do_op(OP_DUP, 64'd0);
        check("dup_depth", 64'(depth), 64'd2);
        check("dup_result", result, 64'h1234_5678_9abc_def0);
        do_op(OP_PUSH, 64'd9);
        do_op(OP_DROP, 64'd0);
        check("drop_depth", 64'(depth), 64'd2);
        check("drop_result", result, 64'h1234_5678_9abc_def0);
        do_op(3'd5, 64'd77);
        do_op(OP_NOP, 64'd77);
        check("rsv_depth", 64'(depth), 64'd2);
        check("rsv_trap", 64'(trap), 64'd0);
        check("rsv_ready", 64'(op_ready), 64'd1);

        // SELECT with cond = 0 picks val2
        do_reset();
        do_op(OP_PUSH, 64'd1);
        do_op(OP_PUSH, 64'd2);
        do_op(OP_PUSH, 64'd0);
        do_op(OP_SELECT, 64'd0);
        check("sel0_result", result, 64'd2);
        check("sel0_depth", 64'(depth), 64'd1);
        check("sel0_empty", 64'(result_empty), 64'd0);
        check("sel0_trap", 64'(trap), 64'd0);

        // SELECT ignores cond bits above 31
        do_reset();
        do_op(OP_PUSH, 64'd1);
        do_op(OP_PUSH, 64'd2);
        do_op(OP_PUSH, 64'h1_0000_0000);
        do_op(OP_SELECT, 64'd0);
        check("selhi_result", result, 64'd2);

        // SELECT with nonzero cond picks val1
        do_reset();
        do_op(OP_PUSH, 64'd1);
        do_op(OP_PUSH, 64'd2);
        do_op(OP_PUSH, 64'd5);
        do_op(OP_SELECT, 64'd0);
        check("sel1_result", result, 64'd1);
        check("sel1_depth", 64'(depth), 64'd1);

        // Overflow: 16 pushes then one more
        do_reset();
        for (int i = 1; i <= 16; i++) do_op(OP_PUSH, 64'(i));
        check("full_depth", 64'(depth), 64'd16);
        check("full_result", result, 64'd16);
        check("full_trap", 64'(trap), 64'd0);
        do_op(OP_PUSH, 64'd99);
        check("ovf_trap", 64'(trap), 64'd2);
        check("ovf_depth", 64'(depth), 64'd16);
        check("ovf_ready", 64'(op_ready), 64'd0);
        check("ovf_result", result, 64'd16);
        do_op(OP_DROP, 64'd0);
        do_op(OP_PUSH, 64'd55);
        check("trapped_depth", 64'(depth), 64'd16);
        check("trapped_trap", 64'(trap), 64'd2);
        check("trapped_result", result, 64'd16);

        // Full stack still accepts SELECT and DROP
        do_reset();
        for (int i = 1; i <= 16; i++) do_op(OP_PUSH, 64'(i));
        do_op(OP_SELECT, 64'd0);
        check("fullsel_depth", 64'(depth), 64'd14);
        check("fullsel_result", result, 64'd14);
        check("fullsel_trap", 64'(trap), 64'd0);
        do_op(OP_DROP, 64'd0);
        check("fulldrop_depth", 64'(depth), 64'd13);
        check("fulldrop_result", result, 64'd13);

        // Underflow from reset, then recovery
        do_reset();
        do_op(OP_DROP, 64'd0);
        check("unf_trap", 64'(trap), 64'd1);
        check("unf_depth", 64'(depth), 64'd0);
        check("unf_empty", 64'(result_empty), 64'd1);
        check("unf_ready", 64'(op_ready), 64'd0);
        do_reset();
        check("rec_trap", 64'(trap), 64'd0);
        check("rec_ready", 64'(op_ready), 64'd1);

        // SELECT underflow with two entries leaves stack intact
        do_op(OP_PUSH, 64'd3);
        do_op(OP_PUSH, 64'd4);
        do_op(OP_SELECT, 64'd0);
        check("selunf_trap", 64'(trap), 64'd1);
        check("selunf_depth", 64'(depth), 64'd2);
        check("selunf_result", result, 64'd4);

        // Reset overrides a simultaneously presented SELECT
        do_reset();
        do_op(OP_PUSH, 64'd7);
        do_op(OP_DUP, 64'd0);
        @(negedge clk);
        op       = OP_SELECT;
        op_valid = 1'b1;
        reset    = 1'b0;
        @(negedge clk);
        op_valid = 1'b0;
        reset    = 1'b1;
        check("rstsel_depth", 64'(depth), 64'd0);
        check("rstsel_result", result, 64'd0);
        check("rstsel_trap", 64'(trap), 64'd0);
        check("rstsel_ready", 64'(op_ready), 64'd1);

`ifdef VALUE_STACK_TYPE_CHECK_EN
        // Type mismatch between val1/val2
        do_reset();
        do_push_t(TY_I32, 64'd1);
        do_push_t(TY_I64, 64'd2);
        do_push_t(TY_I32, 64'd1);
        do_op(OP_SELECT, 64'd0);
        check("type_trap", 64'(trap), 64'd3);
        check("type_depth", 64'(depth), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/value_stack.md
VALUE_STACK -- requirements
Module: value_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, stack capacity 2**DEPTH_LOG2 entries.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port op  input  3  opcode: 0 NOP, 1 PUSH, 2 DROP, 3 SELECT, 4 DUP; 5-7 reserved.
REQ-006 SHALL have port op_valid  input  1  op/op_data presented.
REQ-007 SHALL have port op_data  input  WIDTH  PUSH operand.
REQ-008 SHALL have port op_ready  output  1  block accepts op this cycle.
REQ-009 SHALL have port result  output  WIDTH  current top-of-stack, 0 when empty.
REQ-010 SHALL have port result_empty  output  1  stack holds zero entries.
REQ-011 SHALL have port depth  output  DEPTH_LOG2+1  current entry count.
REQ-012 SHALL have port trap  output  4  sticky trap code, 0 = none.

Function
REQ-013 SHALL accept an op on a rising edge where op_valid and op_ready are both high; otherwise state unchanged.
REQ-014 SHALL implement FSM states RUN and TRAPPED; op_ready high only in RUN.
REQ-015 PUSH SHALL write op_data at index depth, depth+1; result shows op_data the next cycle (latency 1).
REQ-016 DROP SHALL decrement depth; DUP SHALL push a copy of top.
REQ-017 SELECT SHALL pop cond (top), val2, val1 and push (cond!=0 ? val1 : val2), net depth-2, in one cycle.
REQ-018 SELECT cond test SHALL use only bits [31:0] of cond (wasm i32 condition).
REQ-019 NOP and reserved opcodes SHALL change nothing and raise no trap.
REQ-020 Underflow (DROP/DUP at depth 0, SELECT at depth<3) SHALL set trap=1, enter TRAPPED, leave stack unchanged.
REQ-021 Overflow (PUSH/DUP at depth 2**DEPTH_LOG2) SHALL set trap=2, enter TRAPPED, leave stack unchanged.
REQ-022 TRAPPED SHALL be exited only by reset; trap, result, depth hold their values while trapped.
REQ-023 Full stack SHALL still accept DROP and SELECT; depth SHALL never wrap.

Reset
REQ-024 On reset low at a rising edge: depth=0, result=0, result_empty=1, trap=0, state=RUN, op_ready=1 next cycle.
REQ-025 Reset SHALL override any simultaneously accepted op; storage contents need not be cleared.

Configuration
REQ-026 With macro VALUE_STACK_TYPE_CHECK_EN defined, SHALL add input op_type[1:0] (0 i32,1 i64,2 f32,3 f64), store a tag per entry, and trap=3 on SELECT if cond tag!=i32 or val1/val2 tags differ; result tag = val1 tag.
REQ-027 Without VALUE_STACK_TYPE_CHECK_EN, SHALL have no op_type port, no tag storage, and never produce trap=3.

Structure
REQ-028 SHALL take opcode constants (OP_NOP..OP_DUP), trap codes (TRAP_NONE=0, TRAP_UNDERFLOW=1, TRAP_OVERFLOW=2, TRAP_TYPE=3) and type tags from shared package cpu_pkg.
REQ-029 SHALL place entry storage (and tags when enabled) in one sub-module stack_mem: one write port, three combinational read ports (top, top-1, top-2).

Verification
REQ-030 PUSH 1, PUSH 2, PUSH 0, SELECT -> result=2, depth=1, result_empty=0, trap=0.
REQ-031 PUSH 1, PUSH 2, PUSH 0x1_0000_0000, SELECT -> result=2 (upper bits ignored); PUSH 1,2,5, SELECT -> result=1.
REQ-032 16 PUSHes (DEPTH_LOG2=4) then PUSH -> depth=16, trap=2, op_ready=0; further ops ignored.
REQ-033 From reset, DROP -> trap=1, depth=0, result_empty=1; reset low one cycle -> trap=0, op_ready=1.
REQ-034 PUSH 7, DUP, reset low during SELECT acceptance -> depth=0, result=0, trap=0.
REQ-035 With VALUE_STACK_TYPE_CHECK_EN: PUSH i32 1, PUSH i64 2, PUSH i32 1, SELECT -> trap=3, depth=3.
